// File: rtl/mem_data_path_rr.sv
// N-channel processor-to-memory read path.
// Each channel holds one outstanding read. Captured requests are granted
// round-robin into a tagged FIFO, issued one at a time to a shared memory
// port, and the returned word is routed back by tag with a one-cycle done.
//
// Handshakes:
//   channel side: a request transfers at a rising edge where
//     i_ch_ce[i] && o_ch_ready[i]. i_ch_ce while not ready is ignored.
//   memory side: o_mem_ce and o_mem_addr stay stable until an edge where
//     i_mem_valid is high; that edge consumes i_mem_data. i_mem_valid may
//     be combinational from o_mem_ce/o_mem_addr.
module mem_data_path_rr #(
  parameter int NUM_CH     = 4,
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = $clog2(NUM_CH)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          i_base_addr,
  input  logic [NUM_CH-1:0]          i_ch_ce,
  input  logic [NUM_CH*ADDR_W-1:0]   i_ch_addr,
  output logic [NUM_CH-1:0]          o_ch_ready,
  output logic [NUM_CH*DATA_W-1:0]   o_ch_data,
  output logic [NUM_CH-1:0]          o_ch_done,
  output logic                       o_mem_ce,
  output logic [ADDR_W-1:0]          o_mem_addr,
  input  logic                       i_mem_valid,
  input  logic [DATA_W-1:0]          i_mem_data,
  output logic                       o_dbg_busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // The FIFO must be able to hold one entry per channel so a grant is never lost.
  if (FIFO_DEPTH < NUM_CH) begin : g_depth_check
    $error("mem_data_path_rr: FIFO_DEPTH must be >= NUM_CH");
  end

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_CH-1:0]   r_pending;
  logic [NUM_CH-1:0]   r_queued;
  logic [ADDR_W-1:0]   r_addr_lat [NUM_CH];
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_fifo_id   [FIFO_DEPTH];
  logic [ADDR_W-1:0]   r_fifo_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [ID_W-1:0]     r_cur_id;
  logic [DATA_W-1:0]   r_ch_data [NUM_CH];
  logic [NUM_CH-1:0]   r_ch_done;

  logic [NUM_CH-1:0]   w_req;
  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_id;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_complete;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign w_req   = r_pending & ~r_queued;
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = w_grant_vld && !w_full;

  // Round-robin grant: nearest requester after r_rr_ptr, wrapping around.
  always_comb begin
    logic [ID_W-1:0] v_idx;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    v_idx       = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      v_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_CH);
      if (w_req[v_idx]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = v_idx;
      end
    end
  end

  // Channel capture and in-flight bookkeeping; completion releases the channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_queued  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_addr_lat[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_ch_ce[i] && !r_pending[i]) begin
          r_pending[i]  <= 1'b1;
          r_addr_lat[i] <= i_ch_addr[i*ADDR_W +: ADDR_W];
        end else if (w_complete && r_cur_id == ID_W'(i)) begin
          r_pending[i] <= 1'b0;
        end
        if (w_push && w_grant_id == ID_W'(i)) begin
          r_queued[i] <= 1'b1;
        end else if (w_complete && r_cur_id == ID_W'(i)) begin
          r_queued[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer follows the last channel pushed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rr_ptr <= '0;
    else if (w_push) r_rr_ptr <= w_grant_id;
  end

  // Request FIFO storage; contents are only meaningful below r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]   <= w_grant_id;
      r_fifo_addr[r_wr_ptr] <= r_addr_lat[w_grant_id];
    end
  end

  // Request FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  // Issue FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Issue FSM next state: pop in IDLE, wait for mem_valid in BUSY.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (i_mem_valid) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Memory address and tag are registered at pop; base_addr is sampled here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_addr <= '0;
      r_cur_id   <= '0;
    end else if (w_pop) begin
      r_mem_addr <= i_base_addr + r_fifo_addr[r_rd_ptr];
      r_cur_id   <= r_fifo_id[r_rd_ptr];
    end
  end

  // Return path: route the word by tag and pulse that channel's done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ch_done <= '0;
      for (int i = 0; i < NUM_CH; i++) r_ch_data[i] <= '0;
    end else begin
      r_ch_done <= '0;
      if (w_complete) begin
        r_ch_data[r_cur_id] <= i_mem_data;
        r_ch_done[r_cur_id] <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign o_ch_data[g*DATA_W +: DATA_W] = r_ch_data[g];
  end

  assign o_ch_ready = ~r_pending;
  assign o_ch_done  = r_ch_done;
  assign o_mem_ce   = (r_state == ST_BUSY);
  assign o_mem_addr = r_mem_addr;
  assign o_dbg_busy = (r_state == ST_BUSY);

endmodule

// File: doc/mem_data_path_rr.md
Name: mem_data_path_rr

Overview:
- Parametrised N-channel successor of the 4-channel processor-to-ROM data path.
- Each channel can hold one outstanding read.
- Requests are arbitrated round-robin into a tagged request FIFO, then issued one at a time to a shared memory port with a valid handshake.
- The returned word is routed by channel tag back to the requesting core with a one-cycle done pulse.
- Adds over the previous block: per-channel ready back-pressure, round-robin fairness, variable memory latency, configurable widths, depth and channel count.

Parameters:
- NUM_CH, 4, number of processor channels (2..16).
- ADDR_W, 8, address width.
- DATA_W, 32, memory word width.
- FIFO_DEPTH, 4, request FIFO entries; must be >= NUM_CH (elaboration error otherwise).
- ID_W, $clog2(NUM_CH), channel tag width; derived, do not override.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- base_addr  in  ADDR_W  offset added to every channel address.
- ch_ce  in  NUM_CH  per-channel request strobe.
- ch_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at bits [i*ADDR_W +: ADDR_W].
- ch_ready  out  NUM_CH  channel may present a request.
- ch_data  out  NUM_CH*DATA_W  per-channel returned word, registered.
- ch_done  out  NUM_CH  one-cycle pulse: ch_data for that channel updated.
- mem_ce  out  1  memory read enable, held until mem_valid.
- mem_addr  out  ADDR_W  memory address.
- mem_valid  in  1  memory data valid; may be combinational from mem_ce/mem_addr.
- mem_data  in  DATA_W  memory read data.

Behaviour:
- Reset (async assert, sync-release safe):
  - pending, queued, FIFO pointers/count, rr pointer = 0; FSM = IDLE.
  - mem_ce = 0, mem_addr = 0, ch_done = 0, ch_data = 0, ch_ready = all 1.
  - Reset mid-transaction drops all in-flight requests; no done is produced for them.
- Channel capture:
  - ch_ready[i] = ~pending[i].
  - ch_ce[i] && ch_ready[i] at an edge sets pending[i] and latches ch_addr[i].
  - ch_ce[i] while not ready is ignored; no error.
- Arbiter:
  - Each cycle, among channels with pending && !queued, grants one round-robin, searching from rr_ptr+1 with wrap.
  - If the FIFO is not full, pushes {id, latched addr}, sets queued[id], and sets rr_ptr = id.
  - At most one push per cycle. Because FIFO_DEPTH >= NUM_CH, the FIFO never overflows; full only gates the push.
- Issue FSM:
  - IDLE: if the FIFO is not empty, pop the head. Register mem_addr = (base_addr + addr) mod 2^ADDR_W and cur_id = id; assert mem_ce next cycle; go to BUSY.
  - BUSY: mem_ce = 1, mem_addr stable.
    - mem_valid = 0: stay in BUSY, no timeout.
    - mem_valid = 1 at an edge: ch_data[cur_id] <= mem_data; ch_done[cur_id] pulses the following cycle; pending[cur_id] and queued[cur_id] clear; mem_ce drops; go to IDLE.
  - Back-to-back: in the cycle ch_done is high the FSM is in IDLE and may pop, so mem_ce is low for exactly one cycle between transactions.
- Latency: with a combinational memory and an idle block, ch_ce at cycle 0 gives:
  - cycle 1: pending set
  - cycle 2: FIFO non-empty
  - cycle 3: mem_ce = 1
  - cycle 4: ch_done = 1
  - Minimum 4 cycles; each extra memory wait cycle adds 1.
- Simultaneous events:
  - ch_ready[i] is high in the ch_done[i] cycle; a new ch_ce[i] then is accepted.
  - base_addr is sampled at pop, not at capture.
  - Multiple simultaneous ch_ce are all captured in one cycle; they enqueue one per cycle in round-robin order.
- ch_data[i] holds its value until the next ch_done[i]. Only one ch_done bit is ever high in a cycle.

Test Plan:
- Single request: reset, base_addr=0x10, ch_ce[2]=1 with addr 0x05 at cycle 0, memory combinational returning 0xA5A50015 for addr 0x15 -> mem_addr=0x15 at cycle 3; ch_done=4'b0100 at cycle 4; ch_data[2]=0xA5A50015; ch_ready[2] low in cycles 1-3.
- Round-robin fairness: all four ch_ce in the same cycle after reset (rr_ptr=0) -> done order ch1, ch2, ch3, ch0, spaced 2 cycles apart; repeat burst -> order continues ch1, ch2, ch3, ch0.
- Memory stall: mem_valid delayed 5 cycles -> mem_ce and mem_addr held stable for 5 extra cycles; done arrives at cycle 9; other channels stay queued with ready low.
- Address wrap: base_addr=0xF0, addr=0x20 -> mem_addr=0x10.
- Ignored and re-issue: ch_ce[0] held high continuously -> exactly one capture per done; new capture in the done cycle; no duplicate FIFO entries.
- Reset mid-BUSY: assert rst while mem_ce=1 with 3 pending -> mem_ce=0, ch_ready=all 1, no ch_done after release; a fresh request completes in 4 cycles.
